// File: rtl/pid_error_gen_if.sv
// PID error interface: the signed error and not_pedaling flag handed from the
// error generator (master) to the PID block (slave).
interface pid_error_gen_if;
   logic signed [12:0] error;
   logic               not_pedaling;

   modport master (output error, output not_pedaling);
   modport slave  (input  error, input  not_pedaling);
endinterface

// File: rtl/pid_error_gen.sv
// pid_error_gen: conditions cadence, torque, incline and motor current into the
// signed 13-bit error and not_pedaling flag consumed by the PID block.
module pid_error_gen #(
   parameter int          FAST_SIM   = 0,
   parameter logic [11:0] TORQUE_MIN = 12'h380
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cadence,
   input  logic [11:0]        torque,
   input  logic [11:0]        avg_curr,
   input  logic signed [12:0] incline,
   pid_error_gen_if.master    pid
);

   localparam int WIN_W  = (FAST_SIM != 0) ? 12 : 24;
   localparam int TICK_W = (FAST_SIM != 0) ? 8 : 14;
   localparam logic [WIN_W-1:0]  WIN_ONE  = {{(WIN_W-1){1'b0}}, 1'b1};
   localparam logic [TICK_W-1:0] TICK_ONE = {{(TICK_W-1){1'b0}}, 1'b1};

   logic              cad_sync1_r;
   logic              cad_sync2_r;
   logic              cad_sync3_r;
   logic [WIN_W-1:0]  win_cnt_r;
   logic [4:0]        edge_cnt_r;
   logic [4:0]        cadence_filt_r;
   logic              not_pedaling_r;
   logic [15:0]       tq_acc_r;
   logic [TICK_W-1:0] tick_cnt_r;
   logic [13:0]       cu_acc_r;
   logic [12:0]       error_r;

   logic              cad_rise_s;
   logic              win_done_s;
   logic              curr_tick_s;
   logic [4:0]        edge_inc_s;
   logic [4:0]        filt_next_s;
   logic [11:0]       avg_torque_s;
   logic [11:0]       torque_off_s;
   logic [11:0]       curr_filt_s;
   logic [11:0]       target_s;
   logic [8:0]        incline_factor_s;
   logic [20:0]       tq_prod_s;
   logic [12:0]       t1_s;
   logic [17:0]       t2_prod_s;
   logic [13:0]       t2_s;
   logic [12:0]       error_next_s;

   assign cad_rise_s   = cad_sync2_r & ~cad_sync3_r;
   assign win_done_s   = &win_cnt_r;
   assign curr_tick_s  = &tick_cnt_r;
   assign edge_inc_s   = (&edge_cnt_r) ? edge_cnt_r : edge_cnt_r + 5'd1;
   assign filt_next_s  = cad_rise_s ? edge_inc_s : edge_cnt_r;
   assign avg_torque_s = tq_acc_r[15:4];
   assign curr_filt_s  = cu_acc_r[13:2];

   // Torque dead-band removal and incline clamp; in-range incline + 256 is an MSB flip.
   always_comb begin
      torque_off_s     = 12'd0;
      incline_factor_s = 9'd0;
      if (avg_torque_s > TORQUE_MIN) begin
         torque_off_s = avg_torque_s - TORQUE_MIN;
      end else begin
         torque_off_s = 12'd0;
      end
      if (incline > 13'sd255) begin
         incline_factor_s = 9'd511;
      end else if (incline < -13'sd256) begin
         incline_factor_s = 9'd0;
      end else begin
         incline_factor_s = {~incline[8], incline[7:0]};
      end
   end

   assign tq_prod_s = {9'd0, torque_off_s} * {12'd0, incline_factor_s};
   assign t1_s      = 13'(tq_prod_s >> 8);
   assign t2_prod_s = {5'd0, t1_s} * {13'd0, cadence_filt_r};
   assign t2_s      = 14'(t2_prod_s >> 4);

   // Target current saturates at full scale.
   always_comb begin
      target_s = 12'd0;
      if (|t2_s[13:12]) begin
         target_s = 12'hFFF;
      end else begin
         target_s = t2_s[11:0];
      end
   end

   assign error_next_s = {1'b0, target_s} - {1'b0, curr_filt_s};

   // Cadence synchronizer plus edge-detect flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         cad_sync1_r <= 1'b0;
         cad_sync2_r <= 1'b0;
         cad_sync3_r <= 1'b0;
      end else begin
         cad_sync1_r <= cadence;
         cad_sync2_r <= cad_sync1_r;
         cad_sync3_r <= cad_sync2_r;
      end
   end

   // Measurement window: an edge arriving with win_done still counts in the closing window.
   always_ff @(posedge clk) begin
      if (rst) begin
         win_cnt_r      <= {WIN_W{1'b0}};
         edge_cnt_r     <= 5'd0;
         cadence_filt_r <= 5'd0;
         not_pedaling_r <= 1'b1;
      end else begin
         win_cnt_r <= win_cnt_r + WIN_ONE;
         if (win_done_s) begin
            cadence_filt_r <= filt_next_s;
            not_pedaling_r <= (filt_next_s < 5'd2);
            edge_cnt_r     <= 5'd0;
         end else if (cad_rise_s) begin
            edge_cnt_r <= edge_inc_s;
         end else begin
            edge_cnt_r <= edge_cnt_r;
         end
      end
   end

   // Torque averager, sampled once per pedal stroke and frozen while not pedaling.
   always_ff @(posedge clk) begin
      if (rst) begin
         tq_acc_r <= 16'd0;
      end else if (cad_rise_s && !not_pedaling_r) begin
         tq_acc_r <= tq_acc_r - {4'd0, tq_acc_r[15:4]} + {4'd0, torque};
      end else begin
         tq_acc_r <= tq_acc_r;
      end
   end

   // Current averager on the slow tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt_r <= {TICK_W{1'b0}};
         cu_acc_r   <= 14'd0;
      end else begin
         tick_cnt_r <= tick_cnt_r + TICK_ONE;
         if (curr_tick_s) begin
            cu_acc_r <= cu_acc_r - {2'd0, cu_acc_r[13:2]} + {2'd0, avg_curr};
         end else begin
            cu_acc_r <= cu_acc_r;
         end
      end
   end

   // Registered error, forced to zero when the rider is not pedaling.
   always_ff @(posedge clk) begin
      if (rst) begin
         error_r <= 13'd0;
      end else if (not_pedaling_r) begin
         error_r <= 13'd0;
      end else begin
         error_r <= error_next_s;
      end
   end

   assign pid.error        = error_r;
   assign pid.not_pedaling = not_pedaling_r;

endmodule

// File: tb/tb_pid_error_gen.sv
// Bench for pid_error_gen (FAST_SIM): arithmetic reference model compared every cycle,
// plus hand-computed checkpoints along a directed cadence/torque/current scenario.
module tb_pid_error_gen;

   logic               clk      = 1'b0;
   logic               rst      = 1'b1;
   logic               cadence  = 1'b0;
   logic [11:0]        torque   = 12'd0;
   logic [11:0]        avg_curr = 12'd0;
   logic signed [12:0] incline  = 13'sd0;

   int n_vec   = 0;
   int n_fail  = 0;
   int drv_k   = 0;
   int pat_n   = 0;
   int pat_per = 100;

   // reference model state
   int          m_k  = 0;
   int          m_ec = 0;
   int          m_cf = 0;
   int          m_tq = 0;
   int          m_cu = 0;
   logic [2:0]  m_h  = 3'd0;
   logic [12:0] m_err = 13'd0;
   logic        m_win;
   logic        m_tick;
   logic        m_ev;

   pid_error_gen_if pid_if ();

   pid_error_gen #(
      .FAST_SIM   (1),
      .TORQUE_MIN (12'h380)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cadence  (cadence),
      .torque   (torque),
      .avg_curr (avg_curr),
      .incline  (incline),
      .pid      (pid_if)
   );

   always #5 clk = ~clk;

   function automatic int f_target(input int tq, input int cf, input int inc);
      int toff;
      int fac;
      int t1;
      int t2;
      toff = tq / 16 - 'h380;
      if (toff < 0) toff = 0;
      fac = inc;
      if (fac > 255) fac = 255;
      if (fac < -256) fac = -256;
      fac = fac + 256;
      t1 = (toff * fac) / 256;
      t2 = (t1 * cf) / 16;
      return (t2 > 4095) ? 4095 : t2;
   endfunction

   // A cadence edge is acted on two clocks after the first clock that samples it high.
   assign m_ev   = m_h[1] & ~m_h[2];
   assign m_win  = ((m_k + 1) % 4096) == 0;
   assign m_tick = ((m_k + 1) % 256) == 0;

   always @(posedge clk) begin
      if (rst) begin
         m_k   <= 0;
         m_h   <= 3'd0;
         m_ec  <= 0;
         m_cf  <= 0;
         m_tq  <= 0;
         m_cu  <= 0;
         m_err <= 13'd0;
      end else begin
         m_k <= m_k + 1;
         m_h <= {m_h[1:0], cadence};
         if (m_win) begin
            m_cf <= (m_ec + int'(m_ev) > 31) ? 31 : m_ec + int'(m_ev);
            m_ec <= 0;
         end else if (m_ev) begin
            m_ec <= (m_ec + 1 > 31) ? 31 : m_ec + 1;
         end
         if (m_ev && m_cf >= 2) m_tq <= m_tq - m_tq / 16 + int'(torque);
         if (m_tick) m_cu <= m_cu - m_cu / 4 + int'(avg_curr);
         m_err <= (m_cf < 2) ? 13'd0 : 13'(f_target(m_tq, m_cf, int'(incline)) - m_cu / 4);
      end
   end

   // Per-cycle comparison against the model, just after each active edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         n_vec++;
         if (pid_if.error !== m_err) begin
            n_fail++;
            if (n_fail < 20)
               $display("FAIL error k=%0d: dut=%0d model=%0d", m_k, pid_if.error, m_err);
         end
         n_vec++;
         if (pid_if.not_pedaling !== (m_cf < 2)) begin
            n_fail++;
            if (n_fail < 20)
               $display("FAIL not_pedaling k=%0d: dut=%0b model=%0b", m_k, pid_if.not_pedaling, (m_cf < 2));
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      int c;
      c = (drv_k - 1) % 4096;
      cadence = (c >= 50) && (((c - 50) / pat_per) < pat_n) && (((c - 50) % pat_per) < 20);
      @(negedge clk);
      drv_k++;
   endtask

   task automatic run_to(input int k);
      while (drv_k < k) step();
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         cadence  = 1'($urandom_range(0, 1));
         torque   = 12'($urandom);
         avg_curr = 12'($urandom);
         incline  = 13'($urandom);
         @(negedge clk);
      end
      check("reset_error", {19'd0, pid_if.error}, 32'd0);
      check("reset_np", {31'd0, pid_if.not_pedaling}, 32'd1);

      torque   = 12'h980;
      avg_curr = 12'd0;
      incline  = 13'sd0;
      cadence  = 1'b0;
      rst      = 1'b0;
      drv_k    = 1;

      // window 1: 10 strokes
      pat_n = 10; pat_per = 100;
      run_to(4096);
      check("np_before_win1", {31'd0, pid_if.not_pedaling}, 32'd1);
      run_to(4097);
      check("model_cf_10", m_cf, 32'd10);
      check("np_after_win1", {31'd0, pid_if.not_pedaling}, 32'd0);

      // window 2: a single stroke drops below the pedaling threshold
      pat_n = 1;
      run_to(8193);
      check("np_after_win2", {31'd0, pid_if.not_pedaling}, 32'd1);
      check("error_after_win2", {19'd0, pid_if.error}, 32'd0);

      // windows 3..7: 40 strokes each, cadence saturates at 31
      pat_n = 40; pat_per = 100;
      run_to(12289);
      check("model_cf_sat", m_cf, 32'd31);
      check("np_sat", {31'd0, pid_if.not_pedaling}, 32'd0);
      incline = 13'sd255;
      run_to(28673);

      // window 8: 16 strokes; target still saturated with cadence 31
      pat_n = 16; pat_per = 250;
      run_to(28681);
      check("error_target_sat", {19'd0, pid_if.error}, 32'd4095);
      run_to(32769);
      check("model_cf_16", m_cf, 32'd16);
      check("model_tq_settled", m_tq, 32'h9800);

      // window 9: incline and current steps with cadence 16
      incline = 13'sd0;
      run_to(32869);
      check("error_incline0", {19'd0, pid_if.error}, 32'd1536);
      incline = 13'sd300;
      run_to(32889);
      check("error_incline_clamp", {19'd0, pid_if.error}, 32'd3066);
      avg_curr = 12'h800;
      run_to(33100);
      check("error_curr_tick1", {19'd0, pid_if.error}, 32'd2554);
      run_to(33356);
      check("error_curr_tick2", {19'd0, pid_if.error}, 32'd2170);
      run_to(33612);
      check("error_curr_tick3", {19'd0, pid_if.error}, 32'd1882);
      incline = -13'sd300;
      run_to(33632);
      check("error_neg_1", {19'd0, pid_if.error}, 32'h1B60);
      run_to(33868);
      check("error_neg_2", {19'd0, pid_if.error}, 32'h1A88);
      run_to(36865);

      // window 10 interrupted by reset; the next window restarts from zero
      pat_n = 3;
      run_to(38865);
      rst = 1'b1;
      step();
      step();
      check("midreset_error", {19'd0, pid_if.error}, 32'd0);
      check("midreset_np", {31'd0, pid_if.not_pedaling}, 32'd1);
      rst   = 1'b0;
      drv_k = 1;
      run_to(4096);
      check("restart_np_before", {31'd0, pid_if.not_pedaling}, 32'd1);
      run_to(4097);
      check("restart_model_cf", m_cf, 32'd3);
      check("restart_np_after", {31'd0, pid_if.not_pedaling}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
